// File: rtl/usb_crc_check_if.sv
// rtl/usb_crc_check_if.sv - serial bit and verdict bus between the unstuffer, the CRC checker and the parser
interface usb_crc_check_if;
    logic       pkt_start;
    logic [1:0] pkt_type;
    logic       bit_in;
    logic       bit_valid;
    logic       pkt_end;
    logic       data_out;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic       crc_ok;
    logic       crc_err;
    logic       len_err;

    modport master (
        output pkt_start, pkt_type, bit_in, bit_valid, pkt_end,
        input  data_out, data_valid, busy, done, crc_ok, crc_err, len_err
    );

    modport slave (
        input  pkt_start, pkt_type, bit_in, bit_valid, pkt_end,
        output data_out, data_valid, busy, done, crc_ok, crc_err, len_err
    );
endinterface

// File: rtl/usb_crc_check.sv
// rtl/usb_crc_check.sv - receive-side USB CRC5/CRC16 checker that strips the CRC field from the bit stream
module usb_crc_check #(
    parameter int MAX_BYTES = 1023,
    parameter int CNT_W     = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    usb_crc_check_if.slave   bus
);
    localparam logic [1:0] TYPE_TOKEN  = 2'b01;
    localparam logic [1:0] TYPE_DATA   = 2'b11;
    localparam logic [1:0] TYPE_HSHAKE = 2'b10;

    localparam logic [4:0]       POLY5    = 5'b00101;
    localparam logic [4:0]       RESID5   = 5'b01100;
    localparam logic [15:0]      POLY16   = 16'h8005;
    localparam logic [15:0]      RESID16  = 16'h800D;
    localparam logic [CNT_W-1:0] MAX_BITS = CNT_W'(MAX_BYTES * 8 + 16);
    localparam logic [CNT_W-1:0] CRC_BITS = CNT_W'(16);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic [4:0]       crc5_q, crc5_d;
    logic [15:0]      crc16_q, crc16_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [15:0]      dl_q, dl_d;
    logic [4:0]       fill_q, fill_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;

    logic       start_ok;
    logic [4:0] width;
    logic       len_ok;
    logic       crc_bad;

    assign start_ok = bus.pkt_start && (bus.pkt_type != 2'b00);

    always_comb begin
        width = 5'd0;
        case (type_q)
            TYPE_TOKEN: width = 5'd5;
            TYPE_DATA:  width = 5'd16;
            default:    width = 5'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            type_q   <= 2'b00;
            crc5_q   <= '0;
            crc16_q  <= '0;
            bitcnt_q <= '0;
            dl_q     <= '0;
            fill_q   <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            crc5_q   <= crc5_d;
            crc16_q  <= crc16_d;
            bitcnt_q <= bitcnt_d;
            dl_q     <= dl_d;
            fill_q   <= fill_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        crc5_d   = crc5_q;
        crc16_d  = crc16_q;
        bitcnt_d = bitcnt_q;
        dl_d     = dl_q;
        fill_d   = fill_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) state_d = RECV;
            end
            RECV: begin
                if (bus.pkt_start) begin
                    // Abort: an invalid new type simply drops back to idle.
                    state_d = start_ok ? RECV : IDLE;
                end else begin
                    if (bus.bit_valid) begin
                        crc5_d  = {crc5_q[3:0], 1'b0}  ^ ((crc5_q[4]  ^ bus.bit_in) ? POLY5  : 5'd0);
                        crc16_d = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ bus.bit_in) ? POLY16 : 16'd0);
                        if (bitcnt_q != {CNT_W{1'b1}}) bitcnt_d = bitcnt_q + 1'b1;
                        if (fill_q == width) begin
                            dvalid_d = 1'b1;
                            case (type_q)
                                TYPE_TOKEN: dout_d = dl_q[4];
                                TYPE_DATA:  dout_d = dl_q[15];
                                default:    dout_d = bus.bit_in;
                            endcase
                        end else begin
                            fill_d = fill_q + 5'd1;
                        end
                        dl_d = {dl_q[14:0], bus.bit_in};
                    end
                    if (bus.pkt_end) state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = start_ok ? RECV : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_ok && (state_q != RECV || bus.pkt_start)) begin
            type_d   = bus.pkt_type;
            crc5_d   = '1;
            crc16_d  = '1;
            bitcnt_d = '0;
            dl_d     = '0;
            fill_d   = '0;
            dvalid_d = 1'b0;
        end
    end

    // (bitcnt-16)%8==0 reduces to bitcnt%8==0 once bitcnt>=16.
    always_comb begin
        len_ok  = 1'b0;
        crc_bad = 1'b0;
        case (type_q)
            TYPE_TOKEN: begin
                len_ok  = (bitcnt_q == CRC_BITS);
                crc_bad = (crc5_q != RESID5);
            end
            TYPE_DATA: begin
                len_ok  = (bitcnt_q >= CRC_BITS) && (bitcnt_q[2:0] == 3'd0) && (bitcnt_q <= MAX_BITS);
                crc_bad = (crc16_q != RESID16);
            end
            TYPE_HSHAKE: begin
                len_ok  = (bitcnt_q == '0);
                crc_bad = 1'b0;
            end
            default: begin
                len_ok  = 1'b0;
                crc_bad = 1'b0;
            end
        endcase
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dvalid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == CHECK);
    assign bus.crc_err    = (state_q == CHECK) && crc_bad;
    assign bus.len_err    = (state_q == CHECK) && !len_ok;
    assign bus.crc_ok     = (state_q == CHECK) && !crc_bad && len_ok;
endmodule

// File: tb/tb_usb_crc_check.sv
// tb/tb_usb_crc_check.sv - scoreboard bench for usb_crc_check
module tb_usb_crc_check;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   done_cnt = 0;

    usb_crc_check_if bus ();

    usb_crc_check #(.MAX_BYTES(1023), .CNT_W(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit         stim_q[$];
    bit         out_q[$];
    logic [2:0] verd_q[$];
    int         end_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_valid) begin
                if (out_q.size() == 0) check_eq("extra_data_valid", 1, 0);
                else check_eq("data_out", {31'd0, bus.data_out}, {31'd0, out_q.pop_front()});
            end
            if (bus.done) begin
                done_cnt++;
                if (verd_q.size() == 0) check_eq("unexpected_done", 1, 0);
                else begin
                    check_eq("verdict{ok,crc,len}", {29'd0, bus.crc_ok, bus.crc_err, bus.len_err},
                             {29'd0, verd_q.pop_front()});
                    check_eq("done_latency", cyc - end_q.pop_front(), 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Payload LSB-first from pat, then the complemented CRC sent MSB-first.
    task automatic build(input int w, input int nbits, input logic [31:0] pat);
        logic [15:0] c;
        logic        fb;
        stim_q.delete();
        c = 16'hFFFF;
        for (int i = 0; i < nbits; i++) begin
            stim_q.push_back(pat[i]);
            if (w == 5) begin
                fb = c[4] ^ pat[i];
                c[4:0] = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'd0);
            end else begin
                fb = c[15] ^ pat[i];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'd0);
            end
        end
        for (int i = w - 1; i >= 0; i--) stim_q.push_back(~c[i]);
    endtask

    task automatic send_pkt(input logic [1:0] t, input int w, input bit coincide, input logic [2:0] exp_v);
        int n;
        n = stim_q.size();
        bus.pkt_start = 1'b1;
        bus.pkt_type  = t;
        tick();
        bus.pkt_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = stim_q[i];
            if (i < n - w) out_q.push_back(stim_q[i]);
            if (coincide && i == n - 1) begin
                bus.pkt_end = 1'b1;
                verd_q.push_back(exp_v);
                end_q.push_back(cyc);
            end
            tick();
        end
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        if (!coincide || n == 0) begin
            bus.pkt_end = 1'b1;
            verd_q.push_back(exp_v);
            end_q.push_back(cyc);
            tick();
        end
        bus.pkt_end = 1'b0;
        for (int i = 0; i < 10 && verd_q.size() != 0; i++) tick();
        check_eq("verdict_pending", verd_q.size(), 0);
        check_eq("data_pending", out_q.size(), 0);
    endtask

    initial begin
        int d0;
        bus.pkt_start = 1'b0;
        bus.pkt_type  = 2'b00;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.pkt_end   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {26'd0, bus.data_out, bus.data_valid, bus.busy, bus.done,
                                 bus.crc_ok, bus.crc_err | bus.len_err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Token: 11 zero bits plus CRC 0,1,0,0,0
        build(5, 11, 32'h0);
        check_eq("token_crc_bits", {27'd0, stim_q[11], stim_q[12], stim_q[13], stim_q[14], stim_q[15]}, 5'b01000);
        send_pkt(2'b01, 5, 1'b0, 3'b100);

        build(5, 11, 32'h0);
        stim_q[3] = ~stim_q[3];
        send_pkt(2'b01, 5, 1'b0, 3'b010);

        build(16, 0, 32'h0);
        send_pkt(2'b11, 16, 1'b0, 3'b100);
        build(16, 8, 32'h0);
        send_pkt(2'b11, 16, 1'b0, 3'b100);
        build(16, 16, $urandom);
        send_pkt(2'b11, 16, 1'b0, 3'b100);

        build(16, 5, 32'h0);
        send_pkt(2'b11, 16, 1'b0, 3'b001);
        build(16, 8, 32'hA5);
        stim_q[20] = ~stim_q[20];
        send_pkt(2'b11, 16, 1'b0, 3'b010);

        stim_q.delete();
        send_pkt(2'b10, 0, 1'b0, 3'b100);
        stim_q.delete();
        stim_q.push_back(1'b1); stim_q.push_back(1'b0); stim_q.push_back(1'b1);
        send_pkt(2'b10, 0, 1'b0, 3'b001);

        // Invalid type and stray pkt_end are both ignored
        d0 = done_cnt;
        bus.pkt_start = 1'b1; bus.pkt_type = 2'b00;
        tick();
        bus.pkt_start = 1'b0;
        @(negedge clk);
        check_eq("invalid_type_busy", {31'd0, bus.busy}, 0);
        @(posedge clk); #1 bus.pkt_end = 1'b1;
        tick();
        bus.pkt_end = 1'b0;
        repeat (3) tick();
        check_eq("idle_pkt_end_no_done", done_cnt, d0);

        // Abort a token with three bits, then a clean DATA packet
        d0 = done_cnt;
        bus.pkt_start = 1'b1; bus.pkt_type = 2'b01;
        tick();
        bus.pkt_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
            tick();
        end
        bus.bit_valid = 1'b0;
        @(negedge clk);
        check_eq("recv_busy", {31'd0, bus.busy}, 1);
        @(posedge clk); #1;
        build(16, 8, 32'h3C);
        send_pkt(2'b11, 16, 1'b0, 3'b100);
        check_eq("abort_single_done", done_cnt, d0 + 1);

        // Reset mid-packet
        d0 = done_cnt;
        bus.pkt_start = 1'b1; bus.pkt_type = 2'b11;
        tick();
        bus.pkt_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.bit_valid = 1'b1; bus.bit_in = i[0];
            tick();
        end
        bus.bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", {26'd0, bus.data_out, bus.data_valid, bus.busy, bus.done,
                                    bus.crc_ok, bus.crc_err | bus.len_err}, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();
        check_eq("midrst_busy", {31'd0, bus.busy}, 0);
        check_eq("midrst_no_done", done_cnt, d0);

        // pkt_end on the last bit
        build(5, 11, 32'h0);
        send_pkt(2'b01, 5, 1'b1, 3'b100);
        build(5, 11, 32'h5A3);
        send_pkt(2'b01, 5, 1'b1, 3'b100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
